// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between the fetch
// (read-only) port and the data (read/write) port, with bounded inst starvation.
module mem_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          wr_lat;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(MAX_DSTREAK)) ? v : v + SW'(1);
  endfunction

  assign busy    = (state != IDLE);
  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      wr_lat    <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data wins unless the contested-data streak has hit its bound.
          if (d_req && !(i_req && streak == SW'(MAX_DSTREAK))) begin
            owner     <= 1'b1;
            wr_lat    <= d_wr;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (i_req) streak <= sat_inc(streak);
          end else if (i_req) begin
            owner    <= 1'b0;
            wr_lat   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= i_addr;
            mem_en   <= 1'b1;
            streak   <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          cnt    <= CW'(MEM_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!wr_lat) begin
              if (owner) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
            if (owner) d_valid <= 1'b1;
            else       i_valid <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // Requests are deliberately ignored here so a requester can
          // present its next request in the valid cycle.
          i_valid <= 1'b0;
          d_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency behavioural memory.
module tb_mem_arbiter;
  localparam int MEM_LAT     = 2;
  localparam int MAX_DSTREAK = 4;
  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int PER         = MEM_LAT + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_valid, i_stall;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid, d_stall;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_DSTREAK(MAX_DSTREAK), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: preset image plus a write overlay, read data after MEM_LAT cycles.
  logic [31:0] init_mem [256];
  logic [31:0] wmem     [256];
  logic        wvld     [256];
  logic [31:0] rpipe    [MEM_LAT];

  assign mem_rdata = rpipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      wmem[mem_addr[9:2]] <= mem_wdata;
      wvld[mem_addr[9:2]] <= 1'b1;
    end
    if (mem_en && !mem_wr)
      rpipe[0] <= wvld[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : init_mem[mem_addr[9:2]];
    else
      rpipe[0] <= 32'h0;
    for (int k = 1; k < MEM_LAT; k++) rpipe[k] <= rpipe[k-1];
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({i_valid, d_valid, mem_en, mem_wr, busy, i_stall, d_stall} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {i_valid, d_valid, mem_en, mem_wr, busy, i_stall, d_stall});
    end
    checks++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data i_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h exp all 0",
               i_rdata, d_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b mem_en=%b exp 0 0", busy, mem_en);
    end
  endtask

  task automatic test_inst_read();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h40;
    #1;
    checks++;
    if (i_stall !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL inst_read_c0 i_stall=%b mem_en=%b exp 1 0", i_stall, mem_en);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (k == 1) || i_valid !== (k == 4) || i_stall !== (k != 4)) begin
        errors++;
        $display("FAIL inst_read_c%0d mem_en=%b i_valid=%b i_stall=%b exp %b %b %b",
                 k, mem_en, i_valid, i_stall, k == 1, k == 4, k != 4);
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 32'h40 || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL inst_read_issue mem_addr=%h mem_wr=%b exp 00000040 0", mem_addr, mem_wr);
        end
      end
      if (k == 4) begin
        checks++;
        if (i_rdata !== 32'h00A00093) begin
          errors++;
          $display("FAIL inst_read_data got=%h exp=00a00093", i_rdata);
        end
      end
    end
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i_valid !== 1'b0) begin
      errors++;
      $display("FAIL inst_read_done busy=%b i_valid=%b exp 0 0", busy, i_valid);
    end
  endtask

  task automatic test_data_write();
    int nen = 0;
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_en) nen++;
      if (k == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL write_issue en=%b wr=%b addr=%h wdata=%h exp 1 1 00000100 deadbeef",
                   mem_en, mem_wr, mem_addr, mem_wdata);
        end
      end
      if (k == 4) begin
        checks++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin
          errors++;
          $display("FAIL write_resp d_valid=%b d_rdata=%h exp 1 00000000", d_valid, d_rdata);
        end
      end
    end
    d_req = 1'b0; d_wr = 1'b0;
    checks++;
    if (nen !== 1) begin
      errors++;
      $display("FAIL write_mem_en_count got=%0d exp=1", nen);
    end
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h100;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL readback d_valid=%b d_rdata=%h exp 1 deadbeef", d_valid, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    logic exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int n = 0;
    int run = 1;
    int maxrun = 1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (i_stall) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      if (i_valid || d_valid) begin
        checks++;
        if (d_valid !== exp_seq[n] || i_valid === d_valid) begin
          errors++;
          $display("FAIL grant_%0d d_valid=%b i_valid=%b exp d_valid=%b", n, d_valid, i_valid, exp_seq[n]);
        end
        checks++;
        if (d_valid ? (d_rdata !== 32'h12345678) : (i_rdata !== 32'h11111111)) begin
          errors++;
          $display("FAIL grant_data_%0d d_rdata=%h i_rdata=%h", n, d_rdata, i_rdata);
        end
        n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL priority_count got=%0d exp=10", n);
    end
    checks++;
    if (maxrun > 5 * PER) begin
      errors++;
      $display("FAIL inst_starve max_stall=%0d exp<=%0d", maxrun, 5 * PER);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h10, 32'h14, 32'h18};
    logic [31:0] datas [3] = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    int en_cyc [4];
    logic [31:0] en_addr [4];
    int nen = 0;
    int idx = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = addrs[0];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (nen < 4) begin en_cyc[nen] = c; en_addr[nen] = mem_addr; end
        nen++;
      end
      if (i_valid) begin
        checks++;
        if (idx > 2 || i_rdata !== datas[idx > 2 ? 2 : idx]) begin
          errors++;
          $display("FAIL b2b_data_%0d got=%h exp=%h", idx, i_rdata, datas[idx > 2 ? 2 : idx]);
        end
        idx++;
        if (idx < 3) i_addr = addrs[idx];
        else i_req = 1'b0;
      end
      if (idx >= 3 && c >= 30) break;
    end
    checks++;
    if (nen !== 3 || idx !== 3) begin
      errors++;
      $display("FAIL b2b_count mem_en=%0d valids=%0d exp 3 3", nen, idx);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (en_addr[j] !== addrs[j] || en_cyc[j] !== 1 + j * PER) begin
          errors++;
          $display("FAIL b2b_issue_%0d addr=%h cyc=%0d exp %h %0d", j, en_addr[j], en_cyc[j], addrs[j], 1 + j * PER);
        end
      end
    end
  endtask

  task automatic test_reset_wait();
    int nv = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre busy=%b mem_en=%b exp 1 0", busy, mem_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, busy, i_valid, d_valid} !== 4'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async en=%b busy=%b iv=%b dv=%b i_rdata=%h d_rdata=%h exp all 0",
               mem_en, busy, i_valid, d_valid, i_rdata, d_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || i_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release busy=%b i_valid=%b exp 0 0", busy, i_valid);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (i_valid) nv++;
      checks++;
      if (i_valid !== (k == 4) || mem_en !== (k == 1)) begin
        errors++;
        $display("FAIL rst_service_c%0d i_valid=%b mem_en=%b exp %b %b", k, i_valid, mem_en, k == 4, k == 1);
      end
      if (k == 1 && mem_addr !== 32'h80) begin
        errors++;
        $display("FAIL rst_service_addr got=%h exp=00000080", mem_addr);
      end
      if (k == 4) begin
        checks++;
        if (i_rdata !== 32'h80808080) begin
          errors++;
          $display("FAIL rst_service_data got=%h exp=80808080", i_rdata);
        end
        i_req = 1'b0;
      end
    end
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL rst_valid_count got=%0d exp=1", nv);
    end
  endtask

  task automatic test_drop_mid();
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h304;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h44;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h304) begin
      errors++;
      $display("FAIL drop_issue mem_en=%b mem_addr=%h exp 1 00000304", mem_en, mem_addr);
    end
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hCAFEF00D || i_valid !== 1'b0 || i_stall !== 1'b1) begin
      errors++;
      $display("FAIL drop_resp d_valid=%b d_rdata=%h i_valid=%b i_stall=%b exp 1 cafef00d 0 1",
               d_valid, d_rdata, i_valid, i_stall);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle busy=%b d_valid=%b exp 0 0", busy, d_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h44 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL drop_next_issue en=%b addr=%h wr=%b exp 1 00000044 0", mem_en, mem_addr, mem_wr);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (i_valid !== 1'b1 || i_rdata !== 32'h44444444) begin
      errors++;
      $display("FAIL drop_next_resp i_valid=%b i_rdata=%h exp 1 44444444", i_valid, i_rdata);
    end
    i_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      init_mem[k] = 32'h0;
      wmem[k]     = 32'h0;
      wvld[k]     = 1'b0;
    end
    init_mem[8'h10] = 32'h00A00093;
    init_mem[8'h80] = 32'h11111111;
    init_mem[8'hC0] = 32'h12345678;
    init_mem[8'hC1] = 32'hCAFEF00D;
    init_mem[8'h04] = 32'hA0000001;
    init_mem[8'h05] = 32'hA0000002;
    init_mem[8'h06] = 32'hA0000003;
    init_mem[8'h20] = 32'h80808080;
    init_mem[8'h11] = 32'h44444444;
    test_reset();
    test_inst_read();
    test_data_write();
    test_priority();
    test_back_to_back();
    test_reset_wait();
    test_drop_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one fixed-latency, single-ported unified memory between the fetch stage (instruction port, read-only) and the data path (data port, read/write). It serialises requests, drives the memory port, returns read data, and generates per-port stall signals. The core's combined stall is i_stall | d_stall. Data requests have priority, and a streak counter bounds instruction starvation.

Parameters:
MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata (>=1)
MAX_DSTREAK, 4, consecutive contested data grants allowed before instruction port is forced (>=1)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_req  in  1  instruction read request, held until i_valid
i_addr  in  AW  instruction address
i_rdata  out  DW  instruction read data, held until next instruction response
i_valid  out  1  one-cycle instruction completion pulse
i_stall  out  1  i_req & ~i_valid
d_req  in  1  data request, held until d_valid
d_wr  in  1  1=write, 0=read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rdata  out  DW  data read data, held until next data read response
d_valid  out  1  one-cycle data completion pulse (reads and writes)
d_stall  out  1  d_req & ~d_valid
mem_en  out  1  memory access strobe, one cycle per transaction
mem_wr  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  registered memory address
mem_wdata  out  DW  registered memory write data
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, i_rdata=d_rdata=0, wait counter=0, streak=0. Any in-flight transaction is abandoned. No response is issued after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP. owner register: 0=inst, 1=data.
- IDLE: samples requests at the clock edge.
  - If neither request is high: stay in IDLE.
  - If only one request is high: grant it.
  - If both are high: grant data unless streak==MAX_DSTREAK, in which case grant inst.
  - On grant: latch addr, wr (inst: wr=0), and wdata into mem_* registers; set owner; go to ISSUE.
- Streak rules:
  - Contested data grant (i_req also high): streak+1.
  - Any inst grant: streak clears to 0.
  - Uncontested data grant: streak unchanged.
  - Streak saturates at MAX_DSTREAK.
- ISSUE: mem_en=1 for exactly this cycle; mem_wr=latched wr. Load counter = MEM_LAT-1 and go to WAIT.
- WAIT: mem_en=0.
  - Counter decrements each cycle.
  - When counter==0 (MEM_LAT cycles after ISSUE), capture mem_rdata if the transaction is a read, then go to RESP.
- RESP: pulse the owner's valid for one cycle.
  - Read: owner's rdata updates on entry to RESP and is visible in the same cycle as valid.
  - Write: d_rdata is unchanged.
  - Next state is always IDLE. Requests are not sampled in RESP, so a requester may present its next request combinationally in the valid cycle without being double-serviced.
- Latency: request high in IDLE at cycle 0, ISSUE at cycle 1, valid at cycle MEM_LAT+2. Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Stalls are combinational: x_stall = x_req & ~x_valid.
  - The non-granted port stays stalled through the whole transaction.
- Requester contract: addr/wr/wdata held stable until valid; the arbiter uses its latched copies regardless.
- Request dropped mid-transaction: the transaction completes and valid still pulses. For reads, rdata is still updated.
- mem_addr/mem_wdata hold their last values outside ISSUE. mem_wr=0 whenever mem_en=0.
- The arbiter never issues two mem_en cycles without an intervening RESP.

Test Plan:
- Single inst read, MEM_LAT=2, i_addr=0x40, memory returns 0x00A00093 -> mem_en high cycle 1 with mem_addr=0x40 and mem_wr=0; i_valid at cycle 4 with i_rdata=0x00A00093; i_stall high at cycles 0-3 and low at cycle 4.
- Data write, d_addr=0x100, d_wdata=0xDEADBEEF -> a single mem_en cycle with mem_wr=1 and matching addr/data; d_valid pulses; d_rdata unchanged; a following read of 0x100 returns 0xDEADBEEF.
- Both ports requesting continuously, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak resets after each inst grant; i_stall never exceeds 5*(MEM_LAT+3) cycles.
- Back-to-back inst reads with the requester changing i_addr in the i_valid cycle -> exactly one mem_en per address, with a spacing of MEM_LAT+3 cycles and no duplicate access.
- rst asserted low in the WAIT state -> mem_en, busy, valids, and rdata go to 0 immediately, not waiting for a clock edge; after release, a pending i_req is serviced normally with no stale valid.
- d_req dropped during WAIT of a data read -> d_valid still pulses in RESP and d_rdata updates; the arbiter returns to IDLE and then services a pending i_req.
